pifo_shift_sorter: RTL and testbench

- Sits directly downstream of the WRR rank stage.
- Drains the stage's fall-through (rank, meta) FIFO and inserts each entry into a small register-based PIFO, kept sorted by ascending rank.
- Presents the minimum-rank entry to the egress scheduler, which pops it with a request.
- Entries of equal rank leave in arrival order, which preserves WRR round semantics.

---
 rtl/pifo_pkg.sv | 32 +++
 rtl/pifo_rank_cmp.sv | 26 ++
 rtl/pifo_shift_sorter.sv | 133 +++++++++++++
 tb/tb_pifo_shift_sorter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO blocks: default widths, the slot entry type and rank ordering helpers.
// The serial-number helper is selected in pifo_rank_cmp when PIFO_WRAP_CMP_EN is defined.
package pifo_pkg;

    localparam int PIFO_RANK_WIDTH = 16;
    localparam int PIFO_META_WIDTH = 16;

    typedef struct packed {
        logic                       valid;
        logic [PIFO_RANK_WIDTH-1:0] rank;
        logic [PIFO_META_WIDTH-1:0] meta;
    } pifo_slot_t;

    // Ranks are zero-extended to 32 bits; w is the live rank width (<= 32).
    function automatic logic [31:0] rank_mask(input int unsigned w);
        return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic rank_lt_plain(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
        return (a & rank_mask(w)) < (b & rank_mask(w));
    endfunction

    // a precedes b when (b - a) mod 2^w is nonzero and below half the rank space.
    function automatic logic rank_lt_serial(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [31:0] diff;
        diff = (b - a) & rank_mask(w);
        return (diff != 32'd0) && ((diff & (32'd1 << (w - 1))) == 32'd0);
    endfunction

endpackage

// File: rtl/pifo_rank_cmp.sv
// Per-slot comparator: asserts ins_before when a new rank must land at or below this slot.
// Ordering is serial-number when PIFO_WRAP_CMP_EN is defined, plain unsigned otherwise.
module pifo_rank_cmp
    import pifo_pkg::*;
#(
    parameter int RANK_WIDTH = PIFO_RANK_WIDTH
) (
    input  logic                  slot_valid,
    input  logic [RANK_WIDTH-1:0] slot_rank,
    input  logic [RANK_WIDTH-1:0] new_rank,
    output logic                  ins_before
);

    logic strictly_less;

    // Ties do not count as "before", so equal ranks keep arrival order.
    always_comb begin
`ifdef PIFO_WRAP_CMP_EN
        strictly_less = rank_lt_serial(32'(new_rank), 32'(slot_rank), RANK_WIDTH);
`else
        strictly_less = rank_lt_plain(32'(new_rank), 32'(slot_rank), RANK_WIDTH);
`endif
        ins_before = !slot_valid || strictly_less;
    end

endmodule

// File: rtl/pifo_shift_sorter.sv
// Register-based PIFO fed from the WRR rank stage FIFO; slot 0 always holds the minimum rank.
// Rank ordering follows pifo_rank_cmp (PIFO_WRAP_CMP_EN selects wrap-tolerant compare).
module pifo_shift_sorter
    import pifo_pkg::*;
#(
    parameter int RANK_WIDTH = PIFO_RANK_WIDTH,
    parameter int META_WIDTH = PIFO_META_WIDTH,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rank_valid_in,
    input  logic [RANK_WIDTH-1:0] rank_in,
    input  logic [META_WIDTH-1:0] meta_in,
    output logic                  rank_remove,
    input  logic                  deq_req,
    output logic                  deq_valid,
    output logic [RANK_WIDTH-1:0] deq_rank,
    output logic [META_WIDTH-1:0] deq_meta,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  full
);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [RANK_WIDTH-1:0] rank_q [DEPTH];
    logic [RANK_WIDTH-1:0] rank_d [DEPTH];
    logic [META_WIDTH-1:0] meta_q [DEPTH];
    logic [META_WIDTH-1:0] meta_d [DEPTH];
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;

    // "view" is the slot array after an optional pop; "left" is view shifted up by one.
    logic [DEPTH-1:0]      up_valid, view_valid, left_valid;
    logic [RANK_WIDTH-1:0] up_rank [DEPTH];
    logic [RANK_WIDTH-1:0] view_rank [DEPTH];
    logic [RANK_WIDTH-1:0] left_rank [DEPTH];
    logic [META_WIDTH-1:0] up_meta [DEPTH];
    logic [META_WIDTH-1:0] view_meta [DEPTH];
    logic [META_WIDTH-1:0] left_meta [DEPTH];
    logic [DEPTH-1:0]      ins_before;
    logic [CNT_WIDTH-1:0]  ins_pos;
    logic                  pop, accept;

    // Both handshakes are valid/ready style: an entry moves on a cycle where the producer
    // shows valid (rank_valid_in / deq_valid) and the consumer takes it (rank_remove / deq_req).
    assign pop         = deq_req & valid_q[0];
    assign full        = (occ_q == CNT_WIDTH'(DEPTH));
    assign accept      = rank_valid_in & (~full | pop) & ~rst;
    assign rank_remove = accept;

    assign deq_valid = valid_q[0];
    assign deq_rank  = rank_q[0];
    assign deq_meta  = meta_q[0];
    assign occupancy = occ_q;

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_slot
        if (g < DEPTH - 1) begin : g_up
            assign up_valid[g] = valid_q[g+1];
            assign up_rank[g]  = rank_q[g+1];
            assign up_meta[g]  = meta_q[g+1];
        end else begin : g_top
            assign up_valid[g] = 1'b0;
            assign up_rank[g]  = '0;
            assign up_meta[g]  = '0;
        end

        assign view_valid[g] = pop ? up_valid[g] : valid_q[g];
        assign view_rank[g]  = pop ? up_rank[g]  : rank_q[g];
        assign view_meta[g]  = pop ? up_meta[g]  : meta_q[g];

        if (g > 0) begin : g_left
            assign left_valid[g] = view_valid[g-1];
            assign left_rank[g]  = view_rank[g-1];
            assign left_meta[g]  = view_meta[g-1];
        end else begin : g_bottom
            assign left_valid[g] = 1'b0;
            assign left_rank[g]  = '0;
            assign left_meta[g]  = '0;
        end

        pifo_rank_cmp #(.RANK_WIDTH(RANK_WIDTH)) u_cmp (
            .slot_valid (view_valid[g]),
            .slot_rank  (view_rank[g]),
            .new_rank   (rank_in),
            .ins_before (ins_before[g])
        );
    end

    always_comb begin
        ins_pos = CNT_WIDTH'(DEPTH);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ins_before[i]) ins_pos = CNT_WIDTH'(i);
        end
    end

    always_comb begin
        valid_d = view_valid;
        for (int i = 0; i < DEPTH; i++) begin
            rank_d[i] = view_rank[i];
            meta_d[i] = view_meta[i];
            if (accept && CNT_WIDTH'(i) == ins_pos) begin
                valid_d[i] = 1'b1;
                rank_d[i]  = rank_in;
                meta_d[i]  = meta_in;
            end else if (accept && CNT_WIDTH'(i) > ins_pos) begin
                valid_d[i] = left_valid[i];
                rank_d[i]  = left_rank[i];
                meta_d[i]  = left_meta[i];
            end
        end
        occ_d = occ_q + CNT_WIDTH'(accept) - CNT_WIDTH'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rank_q[i] <= '0;
                meta_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                rank_q[i] <= rank_d[i];
                meta_q[i] <= meta_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pifo_shift_sorter.sv
// Directed bench for pifo_shift_sorter: a fall-through upstream model feeds ranks, a
// negedge monitor scores every pop against hand-computed expected (rank, meta) pairs.
module tb_pifo_shift_sorter;

    localparam int RW = 16;
    localparam int MW = 16;
    localparam int DEPTH = 8;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rank_valid_in = 1'b0;
    logic [RW-1:0] rank_in = '0;
    logic [MW-1:0] meta_in = '0;
    logic          rank_remove;
    logic          deq_req = 1'b0;
    logic          deq_valid;
    logic [RW-1:0] deq_rank;
    logic [MW-1:0] deq_meta;
    logic [CW-1:0] occupancy;
    logic          full;

    logic [31:0] exp_q[$];
    logic [31:0] up_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        rem_s = 1'b0;

    always #5 clk = ~clk;

    pifo_shift_sorter #(
        .RANK_WIDTH (RW),
        .META_WIDTH (MW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rank_valid_in (rank_valid_in),
        .rank_in       (rank_in),
        .meta_in       (meta_in),
        .rank_remove   (rank_remove),
        .deq_req       (deq_req),
        .deq_valid     (deq_valid),
        .deq_rank      (deq_rank),
        .deq_meta      (deq_meta),
        .occupancy     (occupancy),
        .full          (full)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic up_refresh();
        rank_valid_in = (up_q.size() != 0);
        if (up_q.size() != 0) {rank_in, meta_in} = up_q[0];
        else begin
            rank_in = '0;
            meta_in = '0;
        end
    endtask

    task automatic up_push(input logic [RW-1:0] r, input logic [MW-1:0] m);
        up_q.push_back({r, m});
        up_refresh();
    endtask

    task automatic exp_push(input logic [RW-1:0] r, input logic [MW-1:0] m);
        exp_q.push_back({r, m});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Fall-through upstream FIFO: the head leaves on any edge where rank_remove was high.
    always @(negedge clk) rem_s = rank_remove;
    always @(posedge clk) begin
        #1;
        if (rem_s && up_q.size() != 0) void'(up_q.pop_front());
        up_refresh();
    end

    always @(negedge clk) begin
        if (!rst && deq_req && deq_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", {deq_rank, deq_meta});
            end else begin
                check("pop", {deq_rank, deq_meta}, exp_q.pop_front());
            end
        end
    end

    initial begin
        step();
        step();
        check("rst_deq_valid", 32'(deq_valid), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_deq_rank", 32'(deq_rank), 0);
        check("rst_deq_meta", 32'(deq_meta), 0);
        rst = 1'b0;

        // Reset mid-fill: three held entries are discarded, pending rank 5 survives upstream.
        up_push(16'd8, 16'h0108);
        up_push(16'd6, 16'h0106);
        up_push(16'd7, 16'h0107);
        step(); step(); step();
        check("fill3_occupancy", 32'(occupancy), 3);
        up_push(16'd5, 16'h0505);
        exp_push(16'd5, 16'h0505);
        #1 rst = 1'b1;
        #1;
        check("async_deq_valid", 32'(deq_valid), 0);
        check("async_occupancy", 32'(occupancy), 0);
        check("async_rank_remove", 32'(rank_remove), 0);
        check("async_up_valid", 32'(rank_valid_in), 1);
        step();
        rst = 1'b0;
        step();
        check("reaccept_valid", 32'(deq_valid), 1);
        check("reaccept_rank", 32'(deq_rank), 5);
        check("reaccept_occ", 32'(occupancy), 1);
        deq_req = 1'b1;
        step();
        deq_req = 1'b0;
        check("reaccept_drained", 32'(occupancy), 0);

        // Out-of-order inserts with a tie.
        up_push(16'd7, 16'h000A);
        up_push(16'd3, 16'h000B);
        up_push(16'd9, 16'h000C);
        up_push(16'd3, 16'h000D);
        exp_push(16'd3, 16'h000B);
        exp_push(16'd3, 16'h000D);
        exp_push(16'd7, 16'h000A);
        exp_push(16'd9, 16'h000C);
        step(); step(); step(); step();
        check("ooo_occupancy", 32'(occupancy), 4);
        check("ooo_min_meta", 32'(deq_meta), 32'h000B);
        deq_req = 1'b1;
        repeat (4) step();
        deq_req = 1'b0;
        check("ooo_drained_occ", 32'(occupancy), 0);
        check("ooo_drained_valid", 32'(deq_valid), 0);

        // Fill to full, then pop+insert at full occupancy.
        up_push(16'd20, 16'h0300);
        up_push(16'd15, 16'h0301);
        up_push(16'd25, 16'h0302);
        up_push(16'd10, 16'h0303);
        up_push(16'd30, 16'h0304);
        up_push(16'd15, 16'h0305);
        up_push(16'd5,  16'h0306);
        up_push(16'd40, 16'h0307);
        up_push(16'd12, 16'h0308);
        up_push(16'd50, 16'h0309);
        up_push(16'd1,  16'h030A);
        exp_push(16'd5,  16'h0306);
        exp_push(16'd10, 16'h0303);
        exp_push(16'd12, 16'h0308);
        exp_push(16'd1,  16'h030A);
        exp_push(16'd15, 16'h0301);
        exp_push(16'd15, 16'h0305);
        exp_push(16'd20, 16'h0300);
        exp_push(16'd25, 16'h0302);
        exp_push(16'd30, 16'h0304);
        exp_push(16'd40, 16'h0307);
        exp_push(16'd50, 16'h0309);
        repeat (8) step();
        check("full_flag", 32'(full), 1);
        check("full_occupancy", 32'(occupancy), 8);
        check("full_no_remove", 32'(rank_remove), 0);
        step(); step();
        check("full_hold_occ", 32'(occupancy), 8);
        check("full_hold_remove", 32'(rank_remove), 0);
        deq_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("swap_occ", 32'(occupancy), 8);
            check("swap_full", 32'(full), 1);
        end
        step();
        check("swap_end_occ", 32'(occupancy), 7);
        repeat (7) step();
        deq_req = 1'b0;
        check("full_drained_occ", 32'(occupancy), 0);

        // Simultaneous insert and pop with occupancy 2.
        up_push(16'd6, 16'h0406);
        up_push(16'd2, 16'h0402);
        step(); step();
        check("sim_occ_before", 32'(occupancy), 2);
        check("sim_min_before", 32'(deq_rank), 2);
        exp_push(16'd2, 16'h0402);
        exp_push(16'd4, 16'h0404);
        exp_push(16'd6, 16'h0406);
        up_push(16'd4, 16'h0404);
        deq_req = 1'b1;
        step();
        deq_req = 1'b0;
        check("sim_occ_after", 32'(occupancy), 2);
        check("sim_rank_after", 32'(deq_rank), 4);
        check("sim_meta_after", 32'(deq_meta), 32'h0404);
        deq_req = 1'b1;
        step(); step();
        deq_req = 1'b0;

        // Pop request while empty alongside an accepted insert.
        check("empty_valid", 32'(deq_valid), 0);
        up_push(16'd10, 16'h050A);
        deq_req = 1'b1;
        step();
        deq_req = 1'b0;
        check("empty_ins_valid", 32'(deq_valid), 1);
        check("empty_ins_rank", 32'(deq_rank), 10);
        check("empty_ins_occ", 32'(occupancy), 1);
        exp_push(16'd10, 16'h050A);
        deq_req = 1'b1;
        step();
        deq_req = 1'b0;

        // Rank wrap ordering.
        up_push(16'hFFFE, 16'h0601);
        up_push(16'h0002, 16'h0602);
`ifdef PIFO_WRAP_CMP_EN
        exp_push(16'hFFFE, 16'h0601);
        exp_push(16'h0002, 16'h0602);
`else
        exp_push(16'h0002, 16'h0602);
        exp_push(16'hFFFE, 16'h0601);
`endif
        step(); step();
        check("wrap_occ", 32'(occupancy), 2);
        deq_req = 1'b1;
        step(); step();
        deq_req = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("exp_drained", 32'(exp_q.size()), 0);
        check("final_occ", 32'(occupancy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
